// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline stall/bubble sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package pipe_ctrl_pkg;

  // Sequencer states: normal flow, or E is held by a multi-cycle mul/div
  typedef enum logic [0:0] {
    PIPE_RUN     = 1'b0,
    PIPE_MD_BUSY = 1'b1
  } pipe_state_e;

  // Default build-time settings
  localparam int DEF_MD_CYCLES   = 4;
  localparam int DEF_MEM_TIMEOUT = 255;
  localparam int DEF_CNT_W       = 8;

  // Architectural register index width
  localparam int REG_W = 5;

  // Value loaded into the mul/div counter on start; MD_CYCLES==1 never loads it
  function automatic int md_load_value(input int md_cycles);
    return (md_cycles > 1) ? (md_cycles - 2) : 0;
  endfunction

endpackage

// File: rtl/pipe_ctrl_if.sv
// Hazard inputs and stall/bubble outputs between the pipeline and its sequencer.
// Latency: n/a (wiring only).
// Backpressure: n/a; stall pins are the backpressure to the pipeline registers.
interface pipe_ctrl_if;
  import pipe_ctrl_pkg::*;

  // Hazard sources from the pipeline
  logic             DD_load_i;
  logic [REG_W-1:0] DD_dstE_i;
  logic [REG_W-1:0] FD_rs1_i;
  logic [REG_W-1:0] FD_rs2_i;
  logic             FD_use_rs1_i;
  logic             FD_use_rs2_i;
  logic             E_mispredict_i;
  logic             E_md_start_i;
  logic             M_mem_req_i;
  logic             M_mem_ack_i;

  // Controls back to the pipeline registers
  logic PC_stall_o;
  logic F_stall_o;
  logic F_bubble_o;
  logic D_stall_o;
  logic D_bubble_o;
  logic E_stall_o;
  logic E_bubble_o;
  logic M_bubble_o;
  logic md_busy_o;
  logic md_done_o;
  logic mem_err_o;

  // Pipeline side: supplies hazard info, consumes controls
  modport master (
    output DD_load_i, DD_dstE_i, FD_rs1_i, FD_rs2_i, FD_use_rs1_i, FD_use_rs2_i,
           E_mispredict_i, E_md_start_i, M_mem_req_i, M_mem_ack_i,
    input  PC_stall_o, F_stall_o, F_bubble_o, D_stall_o, D_bubble_o,
           E_stall_o, E_bubble_o, M_bubble_o, md_busy_o, md_done_o, mem_err_o
  );

  // Sequencer side
  modport slave (
    input  DD_load_i, DD_dstE_i, FD_rs1_i, FD_rs2_i, FD_use_rs1_i, FD_use_rs2_i,
           E_mispredict_i, E_md_start_i, M_mem_req_i, M_mem_ack_i,
    output PC_stall_o, F_stall_o, F_bubble_o, D_stall_o, D_bubble_o,
           E_stall_o, E_bubble_o, M_bubble_o, md_busy_o, md_done_o, mem_err_o
  );

endinterface

// File: rtl/pipe_hazard_det.sv
// Load-use hazard compare between the load in E and the source operands in D.
// Latency: combinational, zero cycles.
// Backpressure: none; the result feeds the sequencer's stall decode.
module pipe_hazard_det
  import pipe_ctrl_pkg::*;
(
  input  logic             load,
  input  logic [REG_W-1:0] dst,
  input  logic [REG_W-1:0] rs1,
  input  logic [REG_W-1:0] rs2,
  input  logic             use_rs1,
  input  logic             use_rs2,
  output logic             hazard
);

  logic hit_rs1;
  logic hit_rs2;

  // x0 is hardwired zero, so a load targeting it never creates a dependency
  always_comb begin
    hit_rs1 = use_rs1 && (rs1 == dst);
    hit_rs2 = use_rs2 && (rs2 == dst);
    hazard  = load && (dst != '0) && (hit_rs1 || hit_rs2);
  end

endmodule

// File: rtl/pipe_ctrl.sv
// Stall/bubble sequencer for the 5-stage pipeline (load-use, mispredict, mul/div, mem wait).
// Latency: stall/bubble outputs combinational from state+inputs; state/counters registered.
// Backpressure: a memory wait freezes PC..E and bubbles M; mul/div holds PC/F/D and bubbles E.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int MD_CYCLES   = DEF_MD_CYCLES,
  parameter int MEM_TIMEOUT = DEF_MEM_TIMEOUT,
  parameter int CNT_W       = DEF_CNT_W
) (
  input logic        clk_i,
  input logic        rst,
  pipe_ctrl_if.slave pif
);

  localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);
  localparam logic [CNT_W-1:0] MD_LOAD      = CNT_W'(md_load_value(MD_CYCLES));
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(MEM_TIMEOUT - 1);
  localparam logic             MD_MULTI     = (MD_CYCLES > 1);

  pipe_state_e      state;
  pipe_state_e      state_nxt;
  logic [CNT_W-1:0] md_cnt;
  logic [CNT_W-1:0] md_cnt_nxt;
  logic [CNT_W-1:0] wait_cnt;
  logic             mem_err;
  logic             mem_wait;
  logic             load_use;

  logic pc_stall;
  logic f_stall;
  logic f_bubble;
  logic d_stall;
  logic d_bubble;
  logic e_stall;
  logic e_bubble;
  logic m_bubble;
  logic md_done;

  // A memory access still outstanding in M stalls everything upstream
  assign mem_wait = pif.M_mem_req_i && !pif.M_mem_ack_i;

  pipe_hazard_det u_hazard (
    .load    (pif.DD_load_i),
    .dst     (pif.DD_dstE_i),
    .rs1     (pif.FD_rs1_i),
    .rs2     (pif.FD_rs2_i),
    .use_rs1 (pif.FD_use_rs1_i),
    .use_rs2 (pif.FD_use_rs2_i),
    .hazard  (load_use)
  );

  // Output decode and next-state; memory wait outranks every other condition
  always_comb begin
    pc_stall   = 1'b0;
    f_stall    = 1'b0;
    f_bubble   = 1'b0;
    d_stall    = 1'b0;
    d_bubble   = 1'b0;
    e_stall    = 1'b0;
    e_bubble   = 1'b0;
    m_bubble   = 1'b0;
    md_done    = 1'b0;
    state_nxt  = state;
    md_cnt_nxt = md_cnt;

    if (rst) begin
      // Flush every stage while held in reset
      f_bubble = 1'b1;
      d_bubble = 1'b1;
      e_bubble = 1'b1;
      m_bubble = 1'b1;
    end else if (mem_wait) begin
      // Full freeze; the mul/div count and state hold too
      pc_stall = 1'b1;
      f_stall  = 1'b1;
      d_stall  = 1'b1;
      e_stall  = 1'b1;
      m_bubble = 1'b1;
    end else begin
      unique case (state)
        PIPE_RUN: begin
          if (pif.E_mispredict_i) begin
            // Squash the wrong-path instructions in F and D; a pending
            // load-use consumer is among them, so it needs no stall
            f_bubble = 1'b1;
            d_bubble = 1'b1;
          end else if (pif.E_md_start_i) begin
            if (MD_MULTI) begin
              pc_stall   = 1'b1;
              f_stall    = 1'b1;
              d_stall    = 1'b1;
              e_bubble   = 1'b1;
              md_cnt_nxt = MD_LOAD;
              state_nxt  = PIPE_MD_BUSY;
            end else begin
              md_done = 1'b1;
            end
          end else if (load_use) begin
            // One-cycle hold; the loaded value forwards next cycle
            pc_stall = 1'b1;
            f_stall  = 1'b1;
            d_bubble = 1'b1;
          end
        end
        PIPE_MD_BUSY: begin
          if (md_cnt != '0) begin
            pc_stall   = 1'b1;
            f_stall    = 1'b1;
            d_stall    = 1'b1;
            e_bubble   = 1'b1;
            md_cnt_nxt = md_cnt - CNT_ONE;
          end else begin
            // Final occupancy cycle: result valid, instruction leaves E
            md_done   = 1'b1;
            state_nxt = PIPE_RUN;
          end
        end
        default: begin
          state_nxt = PIPE_RUN;
        end
      endcase
    end
  end

  // State and mul/div counter; reset abandons any operation in flight
  always_ff @(posedge clk_i) begin
    if (rst) begin
      state  <= PIPE_RUN;
      md_cnt <= '0;
    end else begin
      state  <= state_nxt;
      md_cnt <= md_cnt_nxt;
    end
  end

  // Consecutive memory-wait counter (saturating) and sticky timeout flag
  always_ff @(posedge clk_i) begin
    if (rst) begin
      wait_cnt <= '0;
      mem_err  <= 1'b0;
    end else if (mem_wait) begin
      if (wait_cnt != '1) begin
        wait_cnt <= wait_cnt + CNT_ONE;
      end
      if (wait_cnt == TIMEOUT_LAST) begin
        mem_err <= 1'b1;
      end
    end else begin
      wait_cnt <= '0;
    end
  end

  // A branch resolving in E cannot also be a mul/div
  assert property (@(posedge clk_i) disable iff (rst)
                   !(pif.E_mispredict_i && pif.E_md_start_i));

  assign pif.PC_stall_o = pc_stall;
  assign pif.F_stall_o  = f_stall;
  assign pif.F_bubble_o = f_bubble;
  assign pif.D_stall_o  = d_stall;
  assign pif.D_bubble_o = d_bubble;
  assign pif.E_stall_o  = e_stall;
  assign pif.E_bubble_o = e_bubble;
  assign pif.M_bubble_o = m_bubble;
  assign pif.md_done_o  = md_done;
  assign pif.md_busy_o  = (state == PIPE_MD_BUSY) && !rst;
  assign pif.mem_err_o  = mem_err && !rst;

endmodule
